icu_sequencer: RTL and testbench

//  Program sequencer for the MC14500B ICU: owns the program counter, fetches program words from
//  an async-read ROM and issues opcode plus I/O address to the ICU. Acts on the ICU's jmp, rtn,

---
 rtl/icu_sequencer_pkg.sv | 36 +++
 rtl/icu_ret_stack.sv | 48 ++++
 rtl/icu_sequencer.sv | 130 +++++++++++++
 tb/tb_icu_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/icu_sequencer_pkg.sv
// Shared definitions for the MC14500B ICU program sequencer: opcode encoding,
// program-word layout and sequencer state type.
package icu_sequencer_pkg;

    localparam int ICU_OP_W = 4;

    typedef enum logic [ICU_OP_W-1:0] {
        NOPO = 4'h0,
        LD   = 4'h1,
        LDC  = 4'h2,
        AND  = 4'h3,
        ANDC = 4'h4,
        OR   = 4'h5,
        ORC  = 4'h6,
        XNOR = 4'h7,
        STO  = 4'h8,
        STOC = 4'h9,
        IEN  = 4'hA,
        OEN  = 4'hB,
        JMP  = 4'hC,
        RTN  = 4'hD,
        SKZ  = 4'hE,
        NOPF = 4'hF
    } instruction_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

    // A program word is {opcode, addr}: the opcode sits directly above the address field.
    function automatic int word_op_lsb(input int pc_w);
        return pc_w;
    endfunction

endpackage

// File: rtl/icu_ret_stack.sv
// Bounded LIFO of return addresses for the ICU sequencer; combinational top of stack.
module icu_ret_stack #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CNT_W-1:0] sp;
    logic [W-1:0]     mem [DEPTH];
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    assign wr_idx = IDX_W'(sp);
    assign rd_idx = IDX_W'(sp - CNT_W'(1));
    assign full   = (sp == CNT_W'(DEPTH));
    assign empty  = (sp == '0);
    assign top    = mem[rd_idx];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + CNT_W'(1);
        end else if (pop && !empty) begin
            sp <= sp - CNT_W'(1);
        end
    end

    // NOTE: the storage array has no reset; the pointer alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/icu_sequencer.sv
// MC14500B program sequencer: fetches {opcode, addr} words, issues them to the ICU
// and resolves jump, call (NOPO), return and halt (NOPF) with a bounded return stack.
module icu_sequencer
    import icu_sequencer_pkg::*;
#(
    parameter int PC_W        = 8,
    parameter int IO_W        = 4,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_PC    = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic [PC_W-1:0]          rom_addr,
    input  logic [ICU_OP_W+PC_W-1:0] rom_data,
    output instruction_t             i,
    output logic [IO_W-1:0]          io_addr,
    input  logic                     jmp,
    input  logic                     rtn,
    input  logic                     flag_o,
    input  logic                     flag_f,
    output logic                     running,
    output logic                     stk_err
);

    seq_state_t   state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] ir_addr;
    instruction_t ir;

    instruction_t    word_op;
    logic [PC_W-1:0] word_addr;
    logic            in_run;
    logic            push;
    logic            pop;
    logic            stk_full;
    logic            stk_empty;
    logic [PC_W-1:0] stk_top;

    assign word_op   = instruction_t'(rom_data[word_op_lsb(PC_W) +: ICU_OP_W]);
    assign word_addr = rom_data[PC_W-1:0];

    assign rom_addr = pc;
    assign i        = ir;
    assign io_addr  = ir_addr[IO_W-1:0];

    // Stack strobes follow the same priority as the RUN-state decode below.
    assign in_run = (state == RUN);
    assign pop    = in_run && !flag_f && rtn && !stk_empty;
    assign push   = in_run && !flag_f && !rtn && flag_o && !stk_full;

    icu_ret_stack #(
        .W     (PC_W),
        .DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (pc),
        .top   (stk_top),
        .full  (stk_full),
        .empty (stk_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pc      <= PC_W'(RESET_PC);
            ir      <= NOPO;
            ir_addr <= '0;
            running <= 1'b0;
            stk_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !stk_err) begin
                        ir      <= word_op;
                        ir_addr <= word_addr;
                        pc      <= pc + PC_W'(1);
                        running <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (flag_f) begin
                        // pc already points past the NOPF, so a restart resumes there.
                        ir      <= NOPO;
                        ir_addr <= '0;
                        running <= 1'b0;
                        state   <= IDLE;
                    end else if (rtn) begin
                        ir      <= NOPO;
                        ir_addr <= '0;
                        if (stk_empty) begin
                            stk_err <= 1'b1;
                            running <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            pc <= stk_top;
                        end
                    end else if (flag_o) begin
                        ir      <= NOPO;
                        ir_addr <= '0;
                        if (stk_full) begin
                            stk_err <= 1'b1;
                            running <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            pc <= ir_addr;
                        end
                    end else if (jmp) begin
                        // The word prefetched behind the JMP is dropped in favour of a bubble.
                        ir      <= NOPO;
                        ir_addr <= '0;
                        pc      <= ir_addr;
                    end else begin
                        ir      <= word_op;
                        ir_addr <= word_addr;
                        pc      <= pc + PC_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icu_sequencer.sv
// Directed bench for icu_sequencer with a behavioural ICU decode and a bench-owned program ROM.
module tb_icu_sequencer;
    import icu_sequencer_pkg::*;

    localparam int PC_W = 8;
    localparam int IO_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [PC_W-1:0]   rom_addr;
    logic [PC_W+3:0]   rom_data;
    instruction_t      i;
    logic [IO_W-1:0]   io_addr;
    logic              jmp, rtn, flag_o, flag_f;
    logic              running;
    logic              stk_err;

    logic [PC_W+3:0]   rom [256];
    int                checks = 0;
    int                fails  = 0;

    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr];
    assign jmp      = (i == JMP);
    assign rtn      = (i == RTN);
    assign flag_o   = (i == NOPO) && (io_addr != '0);
    assign flag_f   = (i == NOPF);

    icu_sequencer #(
        .PC_W        (PC_W),
        .IO_W        (IO_W),
        .STACK_DEPTH (4),
        .RESET_PC    (0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .i        (i),
        .io_addr  (io_addr),
        .jmp      (jmp),
        .rtn      (rtn),
        .flag_o   (flag_o),
        .flag_f   (flag_f),
        .running  (running),
        .stk_err  (stk_err)
    );

    function automatic logic [PC_W+3:0] w(input instruction_t op, input logic [PC_W-1:0] a);
        return {op, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int k = 0; k < 256; k++) rom[k] = w(LD, 8'h01);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Asynchronous reset: outputs are checked before any clock edge sees rst.
    task automatic test_reset();
        start = 1'b0;
        rst   = 1'b1;
        #2;
        checks++; if (rom_addr !== 8'h00) begin fails++; $display("FAIL reset rom_addr: got %h want 00", rom_addr); end
        checks++; if (i !== NOPO) begin fails++; $display("FAIL reset i: got %h want %h", i, NOPO); end
        checks++; if (io_addr !== 4'h0) begin fails++; $display("FAIL reset io_addr: got %h want 0", io_addr); end
        checks++; if (running !== 1'b0) begin fails++; $display("FAIL reset running: got %b want 0", running); end
        checks++; if (stk_err !== 1'b0) begin fails++; $display("FAIL reset stk_err: got %b want 0", stk_err); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_linear();
        logic [7:0]   ea [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
        instruction_t eo [4] = '{IEN, OEN, LD, STO};
        logic [3:0]   ei [4] = '{4'h1, 4'h2, 4'h3, 4'h5};
        clear_rom();
        rom[0] = w(IEN, 8'h01); rom[1] = w(OEN, 8'h02);
        rom[2] = w(LD, 8'h03);  rom[3] = w(STO, 8'h05);
        do_start();
        for (int s = 0; s < 4; s++) begin
            checks++; if (rom_addr !== ea[s]) begin fails++; $display("FAIL linear s%0d rom_addr: got %h want %h", s, rom_addr, ea[s]); end
            checks++; if (i !== eo[s]) begin fails++; $display("FAIL linear s%0d i: got %h want %h", s, i, eo[s]); end
            checks++; if (io_addr !== ei[s]) begin fails++; $display("FAIL linear s%0d io_addr: got %h want %h", s, io_addr, ei[s]); end
            checks++; if (running !== 1'b1) begin fails++; $display("FAIL linear s%0d running: got %b want 1", s, running); end
            tick();
        end
    endtask

    task automatic test_jump();
        logic [7:0]   ea [4] = '{8'h06, 8'h20, 8'h21, 8'h22};
        instruction_t eo [4] = '{JMP, NOPO, OEN, LD};
        logic [3:0]   ei [4] = '{4'h0, 4'h0, 4'h7, 4'h1};
        clear_rom();
        rom[5]     = w(JMP, 8'h20);
        rom[6]     = w(STOC, 8'h09);
        rom[8'h20] = w(OEN, 8'h07);
        do_start();
        repeat (5) tick();
        for (int s = 0; s < 4; s++) begin
            checks++; if (rom_addr !== ea[s]) begin fails++; $display("FAIL jump s%0d rom_addr: got %h want %h", s, rom_addr, ea[s]); end
            checks++; if (i !== eo[s]) begin fails++; $display("FAIL jump s%0d i: got %h want %h", s, i, eo[s]); end
            checks++; if (io_addr !== ei[s]) begin fails++; $display("FAIL jump s%0d io_addr: got %h want %h", s, io_addr, ei[s]); end
            tick();
        end
    endtask

    // Call to 0x41 returns to 0x11; a second RTN then proves the stack drained back to empty.
    task automatic test_call_return();
        logic [7:0]   ea [9] = '{8'h01, 8'h10, 8'h11, 8'h41, 8'h42, 8'h11, 8'h12, 8'h13, 8'h13};
        instruction_t eo [9] = '{JMP, NOPO, NOPO, NOPO, RTN, NOPO, OR, RTN, NOPO};
        logic [3:0]   ei [9] = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h6, 4'h0, 4'h0};
        logic         er [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        clear_rom();
        rom[0]     = w(JMP, 8'h10);
        rom[8'h10] = w(NOPO, 8'h41);
        rom[8'h41] = w(RTN, 8'h00);
        rom[8'h11] = w(OR, 8'h06);
        rom[8'h12] = w(RTN, 8'h00);
        do_start();
        for (int s = 0; s < 9; s++) begin
            checks++; if (rom_addr !== ea[s]) begin fails++; $display("FAIL call s%0d rom_addr: got %h want %h", s, rom_addr, ea[s]); end
            checks++; if (i !== eo[s]) begin fails++; $display("FAIL call s%0d i: got %h want %h", s, i, eo[s]); end
            checks++; if (io_addr !== ei[s]) begin fails++; $display("FAIL call s%0d io_addr: got %h want %h", s, io_addr, ei[s]); end
            checks++; if (running !== er[s]) begin fails++; $display("FAIL call s%0d running: got %b want %b", s, running, er[s]); end
            checks++; if (stk_err !== !er[s]) begin fails++; $display("FAIL call s%0d stk_err: got %b want %b", s, stk_err, !er[s]); end
            tick();
        end
    endtask

    task automatic test_overflow();
        logic [7:0] ea [10] = '{8'h01, 8'h21, 8'h22, 8'h31, 8'h32, 8'h41, 8'h42, 8'h51, 8'h52, 8'h52};
        logic       er [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        clear_rom();
        rom[0]     = w(NOPO, 8'h21);
        rom[8'h21] = w(NOPO, 8'h31);
        rom[8'h31] = w(NOPO, 8'h41);
        rom[8'h41] = w(NOPO, 8'h51);
        rom[8'h51] = w(NOPO, 8'h61);
        do_start();
        for (int s = 0; s < 10; s++) begin
            logic [3:0] ei;
            ei = (s % 2 == 0 && s < 9) ? 4'h1 : 4'h0;
            checks++; if (rom_addr !== ea[s]) begin fails++; $display("FAIL ovf s%0d rom_addr: got %h want %h", s, rom_addr, ea[s]); end
            checks++; if (i !== NOPO) begin fails++; $display("FAIL ovf s%0d i: got %h want %h", s, i, NOPO); end
            checks++; if (io_addr !== ei) begin fails++; $display("FAIL ovf s%0d io_addr: got %h want %h", s, io_addr, ei); end
            checks++; if (running !== er[s]) begin fails++; $display("FAIL ovf s%0d running: got %b want %b", s, running, er[s]); end
            checks++; if (stk_err !== !er[s]) begin fails++; $display("FAIL ovf s%0d stk_err: got %b want %b", s, stk_err, !er[s]); end
            if (s < 9) tick();
        end
        start = 1'b1;
        repeat (3) tick();
        start = 1'b0;
        checks++; if (running !== 1'b0) begin fails++; $display("FAIL ovf restart running: got %b want 0", running); end
        checks++; if (rom_addr !== 8'h52) begin fails++; $display("FAIL ovf restart rom_addr: got %h want 52", rom_addr); end
        checks++; if (i !== NOPO) begin fails++; $display("FAIL ovf restart i: got %h want %h", i, NOPO); end
        checks++; if (stk_err !== 1'b1) begin fails++; $display("FAIL ovf restart stk_err: got %b want 1", stk_err); end
    endtask

    task automatic test_underflow();
        clear_rom();
        rom[0] = w(RTN, 8'h00);
        do_start();
        checks++; if (i !== RTN) begin fails++; $display("FAIL unf i: got %h want %h", i, RTN); end
        tick();
        checks++; if (stk_err !== 1'b1) begin fails++; $display("FAIL unf stk_err: got %b want 1", stk_err); end
        checks++; if (running !== 1'b0) begin fails++; $display("FAIL unf running: got %b want 0", running); end
        checks++; if (i !== NOPO) begin fails++; $display("FAIL unf i after: got %h want %h", i, NOPO); end
    endtask

    task automatic test_halt_resume();
        clear_rom();
        rom[8] = w(NOPF, 8'h00);
        rom[9] = w(XNOR, 8'h03);
        do_start();
        repeat (8) tick();
        checks++; if (i !== NOPF) begin fails++; $display("FAIL halt i: got %h want %h", i, NOPF); end
        checks++; if (rom_addr !== 8'h09) begin fails++; $display("FAIL halt rom_addr at NOPF: got %h want 09", rom_addr); end
        for (int s = 0; s < 2; s++) begin
            tick();
            checks++; if (running !== 1'b0) begin fails++; $display("FAIL halt idle%0d running: got %b want 0", s, running); end
            checks++; if (rom_addr !== 8'h09) begin fails++; $display("FAIL halt idle%0d rom_addr: got %h want 09", s, rom_addr); end
            checks++; if (i !== NOPO) begin fails++; $display("FAIL halt idle%0d i: got %h want %h", s, i, NOPO); end
        end
        do_start();
        checks++; if (i !== XNOR) begin fails++; $display("FAIL resume i: got %h want %h", i, XNOR); end
        checks++; if (io_addr !== 4'h3) begin fails++; $display("FAIL resume io_addr: got %h want 3", io_addr); end
        checks++; if (rom_addr !== 8'h0A) begin fails++; $display("FAIL resume rom_addr: got %h want 0a", rom_addr); end
        checks++; if (running !== 1'b1) begin fails++; $display("FAIL resume running: got %b want 1", running); end
        rst = 1'b1;
        #1;
        checks++; if (rom_addr !== 8'h00) begin fails++; $display("FAIL midrst rom_addr: got %h want 00", rom_addr); end
        checks++; if (i !== NOPO) begin fails++; $display("FAIL midrst i: got %h want %h", i, NOPO); end
        checks++; if (io_addr !== 4'h0) begin fails++; $display("FAIL midrst io_addr: got %h want 0", io_addr); end
        checks++; if (running !== 1'b0) begin fails++; $display("FAIL midrst running: got %b want 0", running); end
        tick();
        rst = 1'b0;
    endtask

    initial begin
        start = 1'b0;
        clear_rom();
        test_reset();
        test_linear();
        test_reset();
        test_jump();
        test_reset();
        test_call_return();
        test_reset();
        test_overflow();
        test_reset();
        test_underflow();
        test_reset();
        test_halt_resume();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
